// File: rtl/seg7_pkg.sv
// seg7_pkg: shared BCD digit type and 7-segment glyph constants (bit0=a .. bit6=g).
package seg7_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic bcd_valid(bcd_t d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_seg_lut.sv
// bcd_seg_lut: combinational BCD code to segment pattern; codes above 9 show "E".
module bcd_seg_lut
  import seg7_pkg::*;
(
  input  bcd_t       code_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (code_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end
endmodule

// File: rtl/display_7seg_mux.sv
// display_7seg_mux: multiplexed N-digit 7-segment driver with dead time, leading-zero blanking and blink.
module display_7seg_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYCLES    = 1,
  parameter int BLINK_DIV      = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              display,
  output logic [NUM_DIGITS-1:0]   anode
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_INACT = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INACT = {NUM_DIGITS{AN_ACTIVE_LOW}};
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_phase_q, blink_phase_d;
  logic [6:0] display_q, display_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic tick, last_digit, scan_end, blink_wrap, dead, blanked;
  logic [4*NUM_DIGITS-1:0] upper;
  logic [6:0] seg;
  bcd_t digit;
  bcd_seg_lut u_lut (
    .code_i(digit),
    .seg_o (seg)
  );
  // Shifting the word down by the current index leaves exactly the digits j >= idx,
  // which both selects the digit and tests the leading-zero condition.
  always_comb begin
    tick          = prescaler_q == PW'(SCAN_DIV - 1);
    last_digit    = idx_q == IW'(NUM_DIGITS - 1);
    scan_end      = tick && last_digit;
    blink_wrap    = blink_cnt_q == BW'(BLINK_DIV - 1);
    upper         = shadow_q >> {idx_q, 2'b00};
    digit         = bcd_t'(upper);
    blanked       = blank_lz && idx_q != '0 && upper == '0;
    dead          = int'(prescaler_q) < DEAD_CYCLES;
    shadow_d      = load ? bcd_in : shadow_q;
    prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
    idx_d         = !tick ? idx_q : last_digit ? '0 : idx_q + 1'b1;
    blink_cnt_d   = !scan_end ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ (scan_end && blink_wrap);
    display_d     = (blanked ? SEG_OFF : seg) ^ SEG_INACT;
    anode_d       = ((dead || (blink_en && blink_phase_q)) ? '0
                    : NUM_DIGITS'(1) << idx_q) ^ AN_INACT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      prescaler_q   <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      display_q     <= SEG_INACT;
      anode_q       <= AN_INACT;
    end else begin
      shadow_q      <= shadow_d;
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      display_q     <= display_d;
      anode_q       <= anode_d;
    end
  end
  assign display = display_q;
  assign anode   = anode_q;
endmodule

// File: doc/display_7seg_mux.md
Name: display_7seg_mux

Overview:
Multiplexed driver for an N-digit common-anode/cathode 7-segment display, fed with packed BCD digits.
- Latches a BCD word into a shadow register.
- Time-multiplexes the digits with a programmable scan rate and inserts a dead time between digits against ghosting.
- Decodes each digit to segments; invalid codes (>9) show "E".
- Adds optional leading-zero blanking and whole-display blink.
- Sits between the datapath result registers and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits (1..8)
SCAN_DIV, 50000, clock cycles each digit stays selected (>= DEAD_CYCLES+1)
DEAD_CYCLES, 1, cycles at start of each digit slot with all anodes off (0 disables)
BLINK_DIV, 256, full scan periods per blink half-phase (>=1)
SEG_ACTIVE_LOW, 0, 1 inverts display outputs
AN_ACTIVE_LOW, 0, 1 inverts anode outputs

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bcd_in  in  4*NUM_DIGITS  packed digits, digit 0 (least significant) in [3:0]
load  in  1  capture bcd_in into shadow on this edge
blank_lz  in  1  enable leading-zero blanking
blink_en  in  1  enable blink
display  out  7  segments, bit0=a … bit6=g (registered)
anode  out  NUM_DIGITS  digit select, one-hot when active (registered)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shadow=0, prescaler=0, digit_idx=0, blink_cnt=0, blink_phase=0.
  - display and anode both inactive: all 0 logically, inverted per polarity parameters.
- Shadow register:
  - load=1 at an edge: shadow<=bcd_in.
  - Otherwise shadow holds.
  - The new value is visible from the next output update. No tearing: each digit slot uses a single shadow value.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler==SCAN_DIV-1).
  - On tick, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Blink:
  - On tick with digit_idx==NUM_DIGITS-1 (end of a full scan), blink_cnt increments.
  - At BLINK_DIV-1, blink_cnt wraps to 0 and blink_phase toggles.
  - Counters run whether or not blink_en is set.
- Decode, combinational from shadow digit at digit_idx (logical, before inversion):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 10..15 = "E" = 0x79.
- Leading-zero blank:
  - Digit i>0 is blanked (segments 0x00) when blank_lz=1 and every digit j>=i equals 0.
  - Digit 0 is never blanked.
  - Codes >9 count as nonzero.
- Anode (logical): one-hot bit digit_idx. It is forced all-0 when either:
  - prescaler < DEAD_CYCLES; or
  - blink_en=1 and blink_phase=1.
- Output registers:
  - display and anode load every cycle from the decode/anode logic of the current state: latency 1 cycle from state.
  - Polarity inversion is applied before the register, so pins are glitch-free.
- Simultaneous load and tick: the shadow update and the index advance both take effect; the next slot shows the new data.
- Reset asserted mid-scan: all outputs go inactive immediately, without waiting for a clock.
- Reset release: scan restarts at digit 0 with a dead time, displaying shadow=0.
- NUM_DIGITS=1: digit_idx stays 0. The anode pulses off for DEAD_CYCLES each slot.

Decomposition:
- Package seg7_pkg holds:
  - the ten digit segment constants SEG_0..SEG_9, SEG_E=7'h79 and SEG_OFF=7'h00;
  - function/type for the 4-bit BCD digit.
- Sub-module bcd_seg_lut: purely combinational, 4-bit code -> 7-bit segments using the package constants. It is reused by the ALU result display.
- Counters, blanking and blink stay in display_7seg_mux.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_DIV=2, polarities 0):
- Reset then load bcd_in=16'h1234 -> slots cycle digit0..3:
  - display 0x66, 0x4F, 0x5B, 0x06 with anode 0001, 0010, 0100, 1000;
  - anode 0000 on the first cycle of each slot, and a 4-cycle slot period.
- Load 16'h00A7 with blank_lz=1 -> digit3 and digit2 show 0x00; digit1 shows 0x79 ("E"); digit0 shows 0x07.
- Load 16'h0000 with blank_lz=1 -> only digit0 lit with 0x3F; digits 1..3 show 0x00.
- blink_en=1 -> anode all 0 for two full scans (32 cycles), then normal for 32 cycles, repeating; display still sequences.
- Load 16'h5555 issued on the same edge as a tick -> the next slot already shows 0x6D; no slot shows mixed old/new data.
- Assert rst_n=0 mid-slot, asynchronously between edges -> display=0x00 and anode=0000 before the next edge. After release, digit 0 is selected after the dead cycle and shows 0x3F. Repeat with SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1, checking the inverted values (0x7F, 1111).
